// File: rtl/quadencoder_velocity.sv
// rtl/quadencoder_velocity.sv - windowed velocity from a quadrature position count
// Optional period/direction measurement is built when QUADVEL_PERIOD_EN is defined.
module quadencoder_velocity #(
  parameter int BITS   = 32,
  parameter int VBITS  = 24,
  parameter int WINDOW = 10000,
  parameter int PBITS  = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [BITS-1:0]  position,
  input  logic                    clear,
  output logic signed [VBITS-1:0] velocity,
  output logic                    valid
`ifdef QUADVEL_PERIOD_EN
  ,
  output logic [PBITS-1:0]        period,
  output logic                    dir
`endif
);

  localparam int WBITS = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WBITS-1:0] WLAST = WBITS'(WINDOW - 1);

  // Velocity range limits expressed in the wide delta domain.
  localparam logic signed [BITS-1:0] VMAX = {{(BITS-VBITS+1){1'b0}}, {(VBITS-1){1'b1}}};
  localparam logic signed [BITS-1:0] VMIN = {{(BITS-VBITS+1){1'b1}}, {(VBITS-1){1'b0}}};

  logic [WBITS-1:0]        wcnt;
  logic signed [BITS-1:0]  last_pos;
  logic                    primed;
  logic                    sample_edge;
  logic signed [BITS-1:0]  delta;
  logic signed [VBITS-1:0] vel_sat;

  assign sample_edge = (wcnt == WLAST);
  assign delta       = position - last_pos;

  always_comb begin
    vel_sat = delta[VBITS-1:0];
    if (delta > VMAX) begin
      vel_sat = VMAX[VBITS-1:0];
    end else if (delta < VMIN) begin
      vel_sat = VMIN[VBITS-1:0];
    end
  end

  // The first sample edge after reset or clear only captures the reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= '0;
      last_pos <= '0;
      primed   <= 1'b0;
      velocity <= '0;
      valid    <= 1'b0;
    end else if (clear) begin
      wcnt   <= '0;
      primed <= 1'b0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (sample_edge) begin
        wcnt     <= '0;
        last_pos <= position;
        if (primed) begin
          velocity <= vel_sat;
          valid    <= 1'b1;
        end else begin
          primed <= 1'b1;
        end
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

`ifdef QUADVEL_PERIOD_EN
  localparam logic [PBITS-1:0] PMAX = '1;

  logic signed [BITS-1:0] prev_pos;
  logic signed [BITS-1:0] step_d;
  logic [PBITS-1:0]       pcnt;
  logic                   moved;

  assign moved  = (position != prev_pos);
  assign step_d = position - prev_pos;

  // period reads all-ones as soon as pcnt reaches saturation (encoder stalled).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pos <= '0;
      pcnt     <= '0;
      period   <= PMAX;
      dir      <= 1'b0;
    end else begin
      prev_pos <= position;
      if (clear) begin
        pcnt   <= '0;
        period <= PMAX;
      end else if (moved) begin
        pcnt   <= '0;
        period <= (pcnt == PMAX) ? PMAX : pcnt + 1'b1;
        dir    <= ~step_d[BITS-1];
      end else if (pcnt >= PMAX - 1'b1) begin
        pcnt   <= PMAX;
        period <= PMAX;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_quadencoder_velocity.sv
// tb/tb_quadencoder_velocity.sv - directed bench for quadencoder_velocity
module tb_quadencoder_velocity;

  logic              clk;
  logic              rst_n;
  logic signed [31:0] position;
  logic              clear;
  logic signed [7:0] velocity;
  logic              valid;
`ifdef QUADVEL_PERIOD_EN
  logic [7:0]        period;
  logic              dir;
`endif

  int errors = 0;
  int checks = 0;

  quadencoder_velocity #(
    .BITS  (32),
    .VBITS (8),
    .WINDOW(100),
    .PBITS (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .position(position),
    .clear   (clear),
    .velocity(velocity),
`ifdef QUADVEL_PERIOD_EN
    .period  (period),
    .dir     (dir),
`endif
    .valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move position once right after a sample edge and expect one pulse a window later.
  task automatic window(input logic [31:0] np, input int ev);
    position = np;
    for (int k = 1; k < 100; k++) begin
      step();
      chk("win_idle", 32'(valid), 32'd0);
    end
    step();
    chk("win_valid", 32'(valid), 32'd1);
    chk("win_vel", 32'(velocity), 32'(ev));
  endtask

  initial begin
    rst_n    = 1'b0;
    position = '0;
    clear    = 1'b0;
    repeat (3) step();
    chk("rst_vel", 32'(velocity), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
`ifdef QUADVEL_PERIOD_EN
    chk("rst_period", 32'(period), 32'd255);
    chk("rst_dir", 32'(dir), 32'd0);
`endif
    #2 rst_n = 1'b1;

    // Ramp +1 every 10 clk: first pulse after edge 200, then every 100.
    for (int e = 1; e <= 500; e++) begin
      step();
      chk("ramp_valid", 32'(valid), 32'(e >= 200 && e % 100 == 0));
      if (e >= 200 && e % 100 == 0) chk("ramp_vel", 32'(velocity), 32'd10);
      position = e / 10;
    end

    // Signed wrap, saturation and the 0x7FFFFFFF -> 0x80000004 case.
    window(32'h7FFF_FFF0, 127);
    window(32'h7FFF_FFF8, 8);
    window(32'h8000_0000, 8);
    window(32'h8000_0008, 8);
    window(32'h8000_03F0, 127);
    window(32'h8000_0008, -128);
    window(32'h7FFF_FFFF, -9);
    window(32'h8000_0004, 5);

    // Clear coinciding with a sample edge.
    for (int k = 1; k < 100; k++) begin
      step();
      chk("pre_clr_idle", 32'(valid), 32'd0);
    end
    clear    = 1'b1;
    position = position + 3;
    step();
    clear = 1'b0;
    chk("clr_valid", 32'(valid), 32'd0);
    chk("clr_vel_hold", 32'(velocity), 32'd5);
    for (int k = 1; k <= 200; k++) begin
      step();
      chk("post_clr_valid", 32'(valid), 32'(k == 200));
      if (k == 150) position = position + 7;
    end
    chk("post_clr_vel", 32'(velocity), 32'd7);

    // Asynchronous reset mid-window.
    repeat (30) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vel", 32'(velocity), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
`ifdef QUADVEL_PERIOD_EN
    chk("arst_period", 32'(period), 32'd255);
    chk("arst_dir", 32'(dir), 32'd0);
`endif
    repeat (3) step();
    chk("arst_hold_vel", 32'(velocity), 32'd0);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 250; k++) begin
      step();
      chk("rearm_valid", 32'(valid), 32'(k == 200));
      if (k == 150) position = position + 4;
    end
    chk("rearm_vel", 32'(velocity), 32'd4);

`ifdef QUADVEL_PERIOD_EN
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k % 20 == 0) position = position + 1;
    end
    step();
    chk("inc_period", 32'(period), 32'd20);
    chk("inc_dir", 32'(dir), 32'd1);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_period", 32'(period), 32'd255);
    chk("clr_dir_hold", 32'(dir), 32'd1);

    for (int k = 1; k <= 222; k++) begin
      step();
      if (k % 37 == 0) position = position - 1;
    end
    step();
    chk("dec_period", 32'(period), 32'd37);
    chk("dec_dir", 32'(dir), 32'd0);

    repeat (250) step();
    chk("stall_early", 32'(period), 32'd37);
    repeat (10) step();
    chk("stall_sat", 32'(period), 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
